// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid register: state encoding,
// parameter defaults and a state-to-occupancy decode helper.
package pipe_pkg;

  localparam int DATA_W_DEF     = 64;
  localparam int NUM_FIELDS_DEF = 3;
  localparam int CTRL_W_DEF     = 2;
  localparam int CNT_W_DEF      = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MAIN  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  // Number of entries held in a given state.
  function automatic logic [1:0] occ_of(input state_e st);
    logic [1:0] occ;
    case (st)
      ST_EMPTY: occ = 2'd0;
      ST_MAIN:  occ = 2'd1;
      ST_SKID:  occ = 2'd2;
      default:  occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// One pipeline entry register (data + control) with load enable.
// Cleared only by the asynchronous reset; flush never touches it.
module pipe_entry #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_r;

  // Capture d when load is asserted, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= {W{1'b0}};
    end else if (load) begin
      q_r <= d;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid buffer pipeline stage. The main entry drives the
// outputs; the skid entry catches one extra beat so that in_ready can
// be a pure register with no path from out_ready.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int NUM_FIELDS = NUM_FIELDS_DEF,
  parameter int CTRL_W     = CTRL_W_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_FIELDS*DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0]            in_ctrl,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_FIELDS*DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0]            out_ctrl,
  output logic [1:0]                   occupancy,
  output logic [CNT_W-1:0]             stall_cnt
);

  localparam int PAY_W = NUM_FIELDS * DATA_W;
  localparam int ENT_W = PAY_W + CTRL_W;

  state_e             state_r;
  state_e             fsm_nxt_s;
  state_e             state_s;
  logic               in_ready_r;
  logic               out_valid_r;
  logic [1:0]         occupancy_r;
  logic [CNT_W-1:0]   stall_cnt_r;

  logic               in_xfer_s;
  logic               out_xfer_s;
  logic               main_load_s;
  logic               skid_load_s;
  logic               main_sel_skid_s;
  logic [ENT_W-1:0]   in_ent_s;
  logic [ENT_W-1:0]   main_d_s;
  logic [ENT_W-1:0]   main_q_s;
  logic [ENT_W-1:0]   skid_q_s;

  assign in_xfer_s  = in_valid & in_ready_r;
  assign out_xfer_s = out_valid_r & out_ready;
  assign in_ent_s   = {in_ctrl, in_data};
  assign main_d_s   = main_sel_skid_s ? skid_q_s : in_ent_s;

  // Next-state and entry load decisions; flush overrides everything.
  always_comb begin
    fsm_nxt_s       = state_r;
    main_load_s     = 1'b0;
    skid_load_s     = 1'b0;
    main_sel_skid_s = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        if (in_xfer_s) begin
          fsm_nxt_s   = ST_MAIN;
          main_load_s = 1'b1;
        end else begin
          fsm_nxt_s   = ST_EMPTY;
        end
      end
      ST_MAIN: begin
        if (in_xfer_s && out_xfer_s) begin
          fsm_nxt_s   = ST_MAIN;
          main_load_s = 1'b1;
        end else if (in_xfer_s) begin
          fsm_nxt_s   = ST_SKID;
          skid_load_s = 1'b1;
        end else if (out_xfer_s) begin
          fsm_nxt_s   = ST_EMPTY;
        end else begin
          fsm_nxt_s   = ST_MAIN;
        end
      end
      ST_SKID: begin
        if (out_xfer_s) begin
          fsm_nxt_s       = ST_MAIN;
          main_load_s     = 1'b1;
          main_sel_skid_s = 1'b1;
        end else begin
          fsm_nxt_s       = ST_SKID;
        end
      end
      default: begin
        fsm_nxt_s = ST_EMPTY;
      end
    endcase
  end

  assign state_s = flush ? ST_EMPTY : fsm_nxt_s;

  // State register plus registered handshake/occupancy decodes of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_EMPTY;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      occupancy_r <= 2'd0;
    end else begin
      state_r     <= state_s;
      out_valid_r <= (state_s != ST_EMPTY);
      in_ready_r  <= (state_s != ST_SKID);
      occupancy_r <= occ_of(state_s);
    end
  end

  // Saturating count of cycles where downstream back-pressures a valid entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (out_valid_r && !out_ready && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  pipe_entry #(.W(ENT_W)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (main_load_s),
    .d     (main_d_s),
    .q     (main_q_s)
  );

  pipe_entry #(.W(ENT_W)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (skid_load_s),
    .d     (in_ent_s),
    .q     (skid_q_s)
  );

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = main_q_s[PAY_W-1:0];
  assign out_ctrl  = main_q_s[ENT_W-1:PAY_W] & {CTRL_W{out_valid_r}};
  assign occupancy = occupancy_r;
  assign stall_cnt = stall_cnt_r;

endmodule
